// File: rtl/card_grid_renderer.sv
// Memory-game card grid: per-card state, flip/match/clear commands and a
// registered per-pixel colour with a shrink/grow flip animation.
module card_grid_renderer #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int CARD_W      = 90,
  parameter int CARD_H      = 90,
  parameter int ORIGIN_X    = 130,
  parameter int ORIGIN_Y    = 70,
  parameter int PITCH_X     = 100,
  parameter int PITCH_Y     = 100,
  parameter int FLIP_FRAMES = 8,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  input  logic             frame_tick,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             cmd_ready,
  output logic             busy,
  input  logic [IDX_W-1:0] cursor_idx,
  input  logic             cursor_en,
  output logic [6:0]       rom_x,
  output logic [6:0]       rom_y,
  input  logic [2:0]       rom_rgb,
  output logic             cardon,
  output logic [2:0]       rgb
);

  localparam int NCARDS = ROWS * COLS;
  localparam int NSLOTS = 2 ** IDX_W;
  localparam int HALF   = FLIP_FRAMES / 2;
  localparam int STEP   = CARD_W / FLIP_FRAMES;

  localparam logic [1:0] DOWN    = 2'd0;
  localparam logic [1:0] UP      = 2'd1;
  localparam logic [1:0] MATCHED = 2'd2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHRINK = 2'd1;
  localparam logic [1:0] GROW   = 2'd2;

  localparam logic [1:0] OP_UP    = 2'd0;
  localparam logic [1:0] OP_DOWN  = 2'd1;
  localparam logic [1:0] OP_MATCH = 2'd2;

  // Slots beyond NCARDS are never written, so they stay DOWN and fold away.
  logic [1:0]       cards [NSLOTS];
  logic [1:0]       state;
  logic [7:0]       f;
  logic [IDX_W-1:0] tgt;
  logic             accept;
  logic             idx_ok;

  assign cmd_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign idx_ok    = ({{(32-IDX_W){1'b0}}, cmd_idx} < 32'(NCARDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      f     <= 8'd0;
      tgt   <= '0;
      for (int i = 0; i < NSLOTS; i++) cards[i] <= DOWN;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_UP: begin
                if (idx_ok && cards[cmd_idx] == DOWN) begin
                  tgt   <= cmd_idx;
                  f     <= 8'd0;
                  state <= SHRINK;
                end
              end
              OP_DOWN: begin
                if (idx_ok && cards[cmd_idx] == UP) begin
                  tgt   <= cmd_idx;
                  f     <= 8'd0;
                  state <= SHRINK;
                end
              end
              OP_MATCH: begin
                if (idx_ok) cards[cmd_idx] <= MATCHED;
              end
              default: begin
                for (int i = 0; i < NSLOTS; i++) cards[i] <= DOWN;
              end
            endcase
          end
        end
        SHRINK: begin
          if (frame_tick) begin
            f <= f + 8'd1;
            // The face changes at the narrowest point of the animation.
            if (f + 8'd1 == 8'(HALF)) begin
              cards[tgt] <= (cards[tgt] == UP) ? DOWN : UP;
              state      <= GROW;
            end
          end
        end
        GROW: begin
          if (frame_tick) begin
            f <= f - 8'd1;
            if (f == 8'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0]      hx, vy, base, inset, xr32, yr32, right;
  logic             col_hit, row_hit, hit, in_inset, on_edge;
  int               col_i, row_i;
  logic [6:0]       x_rel, y_rel;
  logic [IDX_W-1:0] card_idx;
  logic [1:0]       card_state;
  logic             cardon_n;
  logic [2:0]       rgb_n;

  // Column/row decode compares against per-position constants; no division.
  always_comb begin
    hx         = {22'd0, HCount};
    vy         = {22'd0, VCount};
    base       = 32'd0;
    col_hit    = 1'b0;
    row_hit    = 1'b0;
    col_i      = 0;
    row_i      = 0;
    x_rel      = 7'd0;
    y_rel      = 7'd0;
    for (int c = 0; c < COLS; c++) begin
      base = 32'(ORIGIN_X + c * PITCH_X);
      if (hx >= base && hx <= base + 32'(CARD_W - 1)) begin
        col_hit = 1'b1;
        col_i   = c;
        x_rel   = 7'(hx - base);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      base = 32'(ORIGIN_Y + r * PITCH_Y);
      if (vy >= base && vy <= base + 32'(CARD_H - 1)) begin
        row_hit = 1'b1;
        row_i   = r;
        y_rel   = 7'(vy - base);
      end
    end
    hit = col_hit && row_hit;
    if (!hit) begin
      x_rel = 7'd0;
      y_rel = 7'd0;
    end
    card_idx   = IDX_W'(row_i * COLS + col_i);
    card_state = cards[card_idx];

    inset = (state != IDLE && card_idx == tgt) ? 32'(f) * 32'(STEP) : 32'd0;
    xr32  = {25'd0, x_rel};
    yr32  = {25'd0, y_rel};
    right = 32'(CARD_W - 1) - inset;
    in_inset = (xr32 < inset) || (xr32 > right);
    on_edge  = (xr32 < inset + 32'd2) || (xr32 + 32'd2 > right) ||
               (yr32 < 32'd2) || (yr32 + 32'd2 > 32'(CARD_H - 1));

    cardon_n = 1'b0;
    rgb_n    = 3'b000;
    if (!hit || card_state == MATCHED || in_inset) begin
      cardon_n = 1'b0;
      rgb_n    = 3'b000;
    end else if (cursor_en && card_idx == cursor_idx && on_edge) begin
      cardon_n = 1'b1;
      rgb_n    = 3'b110;
    end else if (card_state == DOWN) begin
      cardon_n = 1'b1;
      rgb_n    = 3'b100;
    end else begin
      cardon_n = 1'b1;
      rgb_n    = rom_rgb;
    end
  end

  assign rom_x = x_rel;
  assign rom_y = y_rel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cardon <= 1'b0;
      rgb    <= 3'b000;
    end else begin
      cardon <= cardon_n;
      rgb    <= rgb_n;
    end
  end

endmodule

// File: doc/card_grid_renderer.md
Name: card_grid_renderer

Overview:
- Parametrised successor to the fixed 4x4 memory-game card drawer.
- Holds a state register for each card in a ROWS x COLS grid and accepts flip, match and clear commands through a valid/ready handshake.
- Animates each flip over FLIP_FRAMES video frames as a horizontal shrink then grow.
- Produces a registered per-pixel colour and coverage flag for the VGA mux; face-up pixels come from an external face ROM.

Parameters:
- ROWS, 4, grid rows.
- COLS, 4, grid columns.
- CARD_W, 90, card width in pixels (<=128).
- CARD_H, 90, card height in pixels (<=128).
- ORIGIN_X, 130, left edge of column 0.
- ORIGIN_Y, 70, top edge of row 0.
- PITCH_X, 100, horizontal card pitch (>=CARD_W).
- PITCH_Y, 100, vertical card pitch (>=CARD_H).
- FLIP_FRAMES, 8, frames per flip animation; even, >=2.
- IDX_W, 4, card index width (2^IDX_W >= ROWS*COLS).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- HCount  in  10  current pixel column.
- VCount  in  10  current pixel row.
- frame_tick  in  1  one-cycle pulse once per frame, during vblank.
- cmd_valid  in  1  command request.
- cmd_op  in  2  00 flip-up, 01 flip-down, 10 mark-matched, 11 clear-all.
- cmd_idx  in  IDX_W  target card, index = row*COLS + col.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- busy  out  1  flip animation in progress.
- cursor_idx  in  IDX_W  card to outline.
- cursor_en  in  1  enables the outline.
- rom_x  out  7  face-ROM column relative to the card's left edge.
- rom_y  out  7  face-ROM row relative to the card's top edge.
- rom_rgb  in  3  face pixel, combinational from rom_x/rom_y in the same cycle.
- cardon  out  1  registered: pixel belongs to a visible card.
- rgb  out  3  registered pixel colour.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all cards DOWN, FSM IDLE, frame counter f=0, rgb=0, cardon=0, busy=0, cmd_ready=0 while rst is high.
- Reset during an animation aborts it; the animating card ends DOWN.
- Card state encoding (2 bits per card): DOWN, UP, MATCHED.
- FSM states: IDLE, SHRINK, GROW. Constants HALF=FLIP_FRAMES/2 and STEP=CARD_W/FLIP_FRAMES (integer division).
- cmd_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
- IDLE, on accepted command:
  - flip-up on a DOWN card, or flip-down on an UP card: latch tgt=cmd_idx, f=0, go SHRINK.
  - flip on a card already in the requested state, or on a MATCHED card: accepted, no effect, stay IDLE.
  - mark-matched: card becomes MATCHED on the next edge, no animation.
  - clear-all: every card becomes DOWN on the next edge.
  - cmd_idx >= ROWS*COLS (except clear-all): accepted, ignored.
- SHRINK: each frame_tick increments f. When f reaches HALF, toggle tgt between DOWN and UP on that same edge and go GROW.
- GROW: each frame_tick decrements f. When f reaches 0, go IDLE.
- A full flip therefore takes exactly FLIP_FRAMES ticks.
- A frame_tick in the same cycle a command is accepted is not counted.
- Inset during animation is f*STEP, applied to tgt only. Pixels with x_rel < inset or x_rel > CARD_W-1-inset are outside the card: cardon=0, rgb=0.
- Pixel decode: a pixel is inside card (r,c) when both hold:
  - ORIGIN_X + c*PITCH_X <= HCount <= ORIGIN_X + c*PITCH_X + CARD_W - 1
  - ORIGIN_Y + r*PITCH_Y <= VCount <= ORIGIN_Y + r*PITCH_Y + CARD_H - 1
- Decode uses comparisons against per-row and per-column constants; no dividers.
- x_rel and y_rel are the offsets from the card's left and top edges. rom_x=x_rel and rom_y=y_rel. Both are 0 when the pixel is outside every card.
- Colour priority, registered one clk after HCount/VCount (latency 1):
  1. Outside any card, or card MATCHED, or in the inset: cardon=0, rgb=000.
  2. cursor_en && card==cursor_idx && x_rel or y_rel within 2 px of an edge (after inset): cardon=1, rgb=110.
  3. DOWN: cardon=1, rgb=100.
  4. UP: cardon=1, rgb=rom_rgb.
- Pixels in the gaps between cards (pitch > size) are outside.

Test Plan:
- Reset: assert rst 2 cycles, then sample pixel (135,75) -> cardon=1 and rgb=100 one cycle later; cmd_ready=1; busy=0.
- Flip-up idx 5 (cmd_op=00), 8 frame_ticks:
  - busy=1 for 8 ticks, then 0.
  - After tick 1, pixel (231,175) (x_rel=1 < 11) -> cardon=0.
  - After tick 4, card 5 is UP and pixel (275,200) -> rgb equals rom_rgb with rom_x=45, rom_y=30.
- Handshake: during an animation, cmd_ready=0 and a held flip of idx 2 is accepted only after the animation finishes; a frame_tick in the acceptance cycle is not counted.
- Mark-matched idx 15, then sample pixel (470,400) -> cardon=0, rgb=000. A following flip-up on idx 15 is a no-op and busy stays 0.
- Cursor: cursor_en=1, cursor_idx=0.
  - Pixel (130,100) -> rgb=110.
  - Pixel (175,115) -> rgb=100.
  - Gap pixel (225,75) -> cardon=0.
- Reset mid-flip at tick 5 on idx 3 -> card 3 DOWN, FSM IDLE; clear-all after several UP cards -> all DOWN on the next cycle.
